// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event counter: channel mode encodings and
// an event popcount helper.
package edge_event_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned POP_W  = 6;

  // Number of set bits in a (zero-extended) channel event vector.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One monitored channel: input sample register, mode-selected edge detect,
// event pulse, toggle flag and event counter.
// Macro EDGE_EVENT_COUNTER_SAT_EN: counter saturates instead of wrapping.
module edge_event_chan
  import edge_event_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             primed,
  input  logic             clr,
  output logic             evt_c,
  output logic             evt_pulse,
  output logic             toggle,
  output logic [CNT_W-1:0] count
);

  logic             in_q;
  logic [CNT_W-1:0] count_nxt;

  // Edge detect between the previous sample and the current input.
  always_comb begin
    evt_c = 1'b0;
    case (mode)
      MODE_RISE: evt_c = primed & ~in_q & in_bit;
      MODE_FALL: evt_c = primed & in_q & ~in_bit;
      MODE_ANY:  evt_c = primed & (in_q ^ in_bit);
      default:   evt_c = 1'b0;
    endcase
  end

  // Counter increment, wrapping or saturating at all-ones.
  always_comb begin
`ifdef EDGE_EVENT_COUNTER_SAT_EN
    count_nxt = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
`else
    count_nxt = count + CNT_W'(1);
`endif
  end

  // Sample input always; clear overrides any event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= 1'b0;
      evt_pulse <= 1'b0;
      toggle    <= 1'b0;
      count     <= '0;
    end else begin
      in_q <= in_bit;
      if (clr) begin
        evt_pulse <= 1'b0;
        toggle    <= 1'b0;
        count     <= '0;
      end else begin
        evt_pulse <= evt_c;
        if (evt_c) begin
          toggle <= ~toggle;
          count  <= count_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/edge_event_counter.sv
// Multi-channel edge detector / event counter with a global event total and
// global toggle. Per-channel logic lives in edge_event_chan.
// Macro EDGE_EVENT_COUNTER_SAT_EN: per-channel counters saturate (global
// counter always wraps).
module edge_event_counter
  import edge_event_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GCNT_W = 10
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  input  logic [NUM_CH-1:0]       In,
  input  logic [2*NUM_CH-1:0]     Mode,
  input  logic                    Clr,
  output logic [NUM_CH-1:0]       EvtPulse,
  output logic [NUM_CH-1:0]       Toggle,
  output logic [NUM_CH*CNT_W-1:0] Count,
  output logic [GCNT_W-1:0]       GlobalCount,
  output logic                    GlobalToggle
);

  logic              primed;
  logic [NUM_CH-1:0] events;
  logic [POP_W-1:0]  ev_cnt;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_chan
      edge_event_chan #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk      (Clk),
        .rst_n    (ResetN),
        .in_bit   (In[c]),
        .mode     (Mode[2*c +: 2]),
        .primed   (primed),
        .clr      (Clr),
        .evt_c    (events[c]),
        .evt_pulse(EvtPulse[c]),
        .toggle   (Toggle[c]),
        .count    (Count[c*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Number of channel events detected this cycle.
  always_comb begin
    ev_cnt = popcount(MAX_CH'(events));
  end

  // Arm detection one cycle after reset so the reset sample is never an edge.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
    end
  end

  // Global event total and toggle; clear drops that cycle's events.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      GlobalCount  <= '0;
      GlobalToggle <= 1'b0;
    end else if (Clr) begin
      GlobalCount  <= '0;
      GlobalToggle <= 1'b0;
    end else if (ev_cnt != '0) begin
      GlobalCount  <= GlobalCount + GCNT_W'(ev_cnt);
      GlobalToggle <= ~GlobalToggle;
    end
  end

endmodule

// File: tb/tb_edge_event_counter.sv
// Self-checking bench for edge_event_counter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_edge_event_counter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned GCNT_W = 10;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int GCNT_MOD = 1 << GCNT_W;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       in_v;
  logic [2*NUM_CH-1:0]     mode_v;
  logic                    clr;
  logic [NUM_CH-1:0]       evt_pulse;
  logic [NUM_CH-1:0]       toggle;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [GCNT_W-1:0]       gcount;
  logic                    gtoggle;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_prev [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_tog  [NUM_CH];
  int m_pls  [NUM_CH];
  int m_primed;
  int m_gcnt;
  int m_gtog;

  edge_event_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GCNT_W(GCNT_W)
  ) dut (
    .Clk         (clk),
    .ResetN      (rst_n),
    .In          (in_v),
    .Mode        (mode_v),
    .Clr         (clr),
    .EvtPulse    (evt_pulse),
    .Toggle      (toggle),
    .Count       (count),
    .GlobalCount (gcount),
    .GlobalToggle(gtoggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int get_count(input int c);
    return int'(count[c*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_prev[c] = 0; m_cnt[c] = 0; m_tog[c] = 0; m_pls[c] = 0;
    end
    m_primed = 0; m_gcnt = 0; m_gtog = 0;
  endtask

  // Apply one clock of the behavioural rules to the model using current inputs.
  task automatic model_step();
    int n;
    int md;
    int cur;
    bit ev;
    n = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      md  = int'(mode_v[2*c +: 2]);
      cur = int'(in_v[c]);
      ev  = 0;
      if (m_primed != 0) begin
        if (md == 1) ev = (m_prev[c] == 0 && cur == 1);
        if (md == 2) ev = (m_prev[c] == 1 && cur == 0);
        if (md == 3) ev = (m_prev[c] != cur);
      end
      if (clr) begin
        m_cnt[c] = 0; m_tog[c] = 0; m_pls[c] = 0;
      end else begin
        m_pls[c] = ev ? 1 : 0;
        if (ev) begin
          m_tog[c] = 1 - m_tog[c];
`ifdef EDGE_EVENT_COUNTER_SAT_EN
          if (m_cnt[c] < CNT_MOD - 1) m_cnt[c] = m_cnt[c] + 1;
`else
          m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
`endif
          n++;
        end
      end
      m_prev[c] = cur;
    end
    if (clr) begin
      m_gcnt = 0; m_gtog = 0;
    end else begin
      m_gcnt = (m_gcnt + n) % GCNT_MOD;
      if (n != 0) m_gtog = 1 - m_gtog;
    end
    m_primed = 1;
  endtask

  task automatic compare_all(input string ph);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s pulse%0d", ph, c), 32'(evt_pulse[c]), 32'(m_pls[c]));
      check($sformatf("%s toggle%0d", ph, c), 32'(toggle[c]), 32'(m_tog[c]));
      check($sformatf("%s count%0d", ph, c), 32'(get_count(c)), 32'(m_cnt[c]));
    end
    check($sformatf("%s gcount", ph), 32'(gcount), 32'(m_gcnt));
    check($sformatf("%s gtoggle", ph), 32'(gtoggle), 32'(m_gtog));
  endtask

  // Inputs are already set (posedge+1); advance one clock and compare.
  task automatic step(input string ph);
    model_step();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  initial begin
    int pulses;
    int base_g;
    int base_t;
    int exp_c1;

    // 1: reset with all inputs high, release, no false edges
    rst_n = 1'b0; in_v = 4'hF; mode_v = 8'hFF; clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset");
    check("t1 evt_pulse", 32'(evt_pulse), 32'd0);
    check("t1 gcount", 32'(gcount), 32'd0);

    // 2: ch0 rise only, 0->1->0->1 gives two events
    mode_v = 8'h01; in_v = 4'h0;
    step("t2");
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      in_v[0] = (i % 2 == 0);
      step("t2");
      pulses += int'(evt_pulse[0]);
    end
    step("t2");
    pulses += int'(evt_pulse[0]);
    check("t2 count0", 32'(get_count(0)), 32'd2);
    check("t2 toggle0", 32'(toggle[0]), 32'd0);
    check("t2 pulses0", 32'(pulses), 32'd2);

    // 3: all channels any-edge, all flip together
    mode_v = 8'hFF;
    step("t3");
    base_g = m_gcnt; base_t = m_gtog;
    in_v = ~in_v;
    step("t3");
    check("t3 gcount+4", 32'(gcount), 32'((base_g + 4) % GCNT_MOD));
    check("t3 gtoggle", 32'(gtoggle), 32'(1 - base_t));
    check("t3 pulses", 32'(evt_pulse), 32'hF);

    // 4: 256 rise events on ch1 from zero
    clr = 1'b1; mode_v = 8'h04; in_v = 4'h0;
    step("t4clr");
    clr = 1'b0;
    for (int i = 0; i < 512; i++) begin
      in_v[1] = ~in_v[1];
      step("t4");
    end
`ifdef EDGE_EVENT_COUNTER_SAT_EN
    exp_c1 = 255;
`else
    exp_c1 = 0;
`endif
    check("t4 count1", 32'(get_count(1)), 32'(exp_c1));
    check("t4 gcount", 32'(gcount), 32'(256 % GCNT_MOD));

    // 5: clear in the same cycle as a ch2 event
    mode_v = 8'h10; in_v = 4'h0;
    step("t5");
    in_v[2] = 1'b1; clr = 1'b1;
    step("t5");
    check("t5 count2", 32'(get_count(2)), 32'd0);
    check("t5 pulse2", 32'(evt_pulse[2]), 32'd0);
    check("t5 gcount", 32'(gcount), 32'd0);
    clr = 1'b0;
    step("t5");
    check("t5 no replay", 32'(evt_pulse[2]), 32'd0);

    // 6: asynchronous reset mid-count
    mode_v = 8'h01; in_v = 4'h0;
    step("t6");
    for (int i = 0; i < 10; i++) begin
      in_v[0] = ~in_v[0];
      step("t6");
    end
    check("t6 count0", 32'(get_count(0)), 32'd5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t6 async");
    check("t6 count all", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_v = 4'hF; mode_v = 8'hFF;
    step("t6 rearm");
    check("t6 rearm gcount", 32'(gcount), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_v   = NUM_CH'($urandom);
      mode_v = (2*NUM_CH)'($urandom);
      clr    = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
